muldiv_unit: RTL



---
 rtl/muldiv_if.sv | 17 +
 rtl/muldiv_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Command/result bundle between the E-stage issue logic and the multiply/divide unit.
// The master drives operands and strobes; the slave returns HI/LO and Busy.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       MDOp;
    logic             Start;
    logic             Kill;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;

    modport master (output A, B, MDOp, Start, Kill, input HI, LO, Busy);
    modport slave  (input A, B, MDOp, Start, Kill, output HI, LO, Busy);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results come from a combinational datapath on the latched operands, released after a fixed latency.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state, state_n;
    op_e              op, op_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] opa, opa_n, opb, opb_n;
    logic [WIDTH-1:0] hi, hi_n, lo, lo_n;

    logic signed [2*WIDTH-1:0] sprod;
    logic        [2*WIDTH-1:0] uprod;
    logic        [WIDTH-1:0]   res_hi, res_lo;

    assign sprod = $signed({{WIDTH{opa[WIDTH-1]}}, opa}) * $signed({{WIDTH{opb[WIDTH-1]}}, opb});
    assign uprod = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};

    // Pending result; divide-by-zero and signed overflow are forced to fixed encodings.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = sprod;
            OP_MULTU: {res_hi, res_lo} = uprod;
            OP_DIV, OP_DIVU: begin
                if (opb == '0) begin
                    res_lo = '1;
                    res_hi = opa;
                end else if (op == OP_DIV && opa == MINNEG && opb == '1) begin
                    res_lo = opa;
                    res_hi = '0;
                end else if (op == OP_DIV) begin
                    res_lo = $signed(opa) / $signed(opb);
                    res_hi = $signed(opa) % $signed(opb);
                end else begin
                    res_lo = opa / opb;
                    res_hi = opa % opb;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op    <= OP_NOP;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            op    <= op_n;
            cnt   <= cnt_n;
            opa   <= opa_n;
            opb   <= opb_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    // Kill overrides everything, including a same-cycle Start; Start is only honoured in IDLE.
    always_comb begin
        state_n = state;
        op_n    = op;
        cnt_n   = cnt;
        opa_n   = opa;
        opb_n   = opb;
        hi_n    = hi;
        lo_n    = lo;
        if (bus.Kill) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        case (bus.MDOp)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                op_n    = op_e'(bus.MDOp);
                                opa_n   = bus.A;
                                opb_n   = bus.B;
                                cnt_n   = (bus.MDOp == OP_MULT || bus.MDOp == OP_MULTU)
                                          ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                                state_n = RUN;
                            end
                            OP_MTHI: hi_n = bus.A;
                            OP_MTLO: lo_n = bus.A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        hi_n    = res_hi;
                        lo_n    = res_lo;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.HI   = hi;
    assign bus.LO   = lo;
    assign bus.Busy = (state == RUN);
endmodule
